// File: rtl/upload_frame_packer.sv
// Packs single-byte handler uploads into AA 55 SRC LEN_H LEN_L payload CSUM frames
// for the host transmitter. Upload side never stalls: overflow bytes are pended or dropped.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | empty, waiting for the first byte of a frame
// S_COLLECT | filling payload buffer; closes on timeout, full buffer or new source
// S_HDR0    | sync byte 0xAA (tx_valid raised on the cycle after entry)
// S_HDR1    | sync byte 0x55
// S_SRC     | source code of the frame
// S_LEN_H   | payload length, high byte
// S_LEN_L   | payload length, low byte
// S_PAY     | payload bytes buf[0..count-1]
// S_CSUM    | mod-256 sum of SRC, LEN_H, LEN_L and payload
module upload_frame_packer #(
  parameter int PAYLOAD_MAX  = 64,
  parameter int IDLE_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upload_req,
  input  logic       upload_valid,
  input  logic [7:0] upload_data,
  input  logic [7:0] upload_source,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int IDX_W = (PAYLOAD_MAX > 1) ? $clog2(PAYLOAD_MAX) : 1;
  localparam int TMR_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [15:0]      CNT_MAX  = 16'(PAYLOAD_MAX);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_COLLECT, S_HDR0, S_HDR1, S_SRC, S_LEN_H, S_LEN_L, S_PAY, S_CSUM
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       buf_mem [PAYLOAD_MAX];
  logic [15:0]      count;
  logic [15:0]      rd_idx;
  logic [TMR_W-1:0] timer;
  logic [7:0]       cur_src;
  logic [7:0]       csum;
  logic             pend_vld;
  logic [7:0]       pend_data;
  logic [7:0]       pend_src;

  logic offer, hs, full, same_src, last_pay;
  logic col_acc, load_new, load_pend, to_pend, drop;

  always_comb begin
    offer     = upload_req && upload_valid;
    hs        = tx_valid && tx_ready;
    full      = (count == CNT_MAX);
    same_src  = (upload_source == cur_src);
    last_pay  = (rd_idx == count);
    col_acc   = (state == S_COLLECT) && offer && !full && same_src;
    load_pend = (state == S_CSUM) && hs && pend_vld;
    // An empty slot at frame end lets a byte arriving on that very cycle open the next frame.
    load_new  = offer && ((state == S_IDLE) || ((state == S_CSUM) && hs && !pend_vld));
    to_pend   = offer && !load_new && !col_acc && (!pend_vld || load_pend);
    drop      = offer && !load_new && !col_acc && pend_vld && !load_pend;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (offer) state_nxt = S_COLLECT;
      S_COLLECT: begin
        if (offer) begin
          if (full || !same_src) state_nxt = S_HDR0;
        end else if (full || (timer == TMR_LAST)) begin
          state_nxt = S_HDR0;
        end
      end
      S_HDR0:    if (hs) state_nxt = S_HDR1;
      S_HDR1:    if (hs) state_nxt = S_SRC;
      S_SRC:     if (hs) state_nxt = S_LEN_H;
      S_LEN_H:   if (hs) state_nxt = S_LEN_L;
      S_LEN_L:   if (hs) state_nxt = S_PAY;
      S_PAY:     if (hs && last_pay) state_nxt = S_CSUM;
      S_CSUM:    if (hs) state_nxt = (load_pend || load_new) ? S_COLLECT : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (load_new)       buf_mem[0] <= upload_data;
    else if (load_pend) buf_mem[0] <= pend_data;
    else if (col_acc)   buf_mem[count[IDX_W-1:0]] <= upload_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      timer     <= '0;
      cur_src   <= '0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
      pend_src  <= '0;
      drop_cnt  <= '0;
    end else begin
      if (load_new) begin
        cur_src <= upload_source;
        count   <= 16'd1;
      end else if (load_pend) begin
        cur_src <= pend_src;
        count   <= 16'd1;
      end else if (col_acc) begin
        count <= count + 16'd1;
      end else if ((state == S_CSUM) && hs) begin
        count <= '0;
      end

      timer <= ((state == S_COLLECT) && (state_nxt == S_COLLECT) && !offer) ? timer + 1'b1 : '0;

      if (to_pend) begin
        pend_vld  <= 1'b1;
        pend_data <= upload_data;
        pend_src  <= upload_source;
      end else if (load_pend) begin
        pend_vld <= 1'b0;
      end

      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Next byte is loaded on the handshake itself so a ready sink sees back-to-back valid cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      rd_idx   <= '0;
      csum     <= '0;
    end else if ((state == S_HDR0) && !tx_valid) begin
      tx_valid <= 1'b1;
      tx_data  <= 8'hAA;
      csum     <= '0;
    end else if (hs) begin
      case (state)
        S_HDR0:  tx_data <= 8'h55;
        S_HDR1:  tx_data <= cur_src;
        S_SRC: begin
          tx_data <= count[15:8];
          csum    <= csum + tx_data;
        end
        S_LEN_H: begin
          tx_data <= count[7:0];
          csum    <= csum + tx_data;
        end
        S_LEN_L: begin
          tx_data <= buf_mem[0];
          rd_idx  <= 16'd1;
          csum    <= csum + tx_data;
        end
        S_PAY: begin
          csum <= csum + tx_data;
          if (last_pay) begin
            tx_data <= csum + tx_data;
          end else begin
            tx_data <= buf_mem[rd_idx[IDX_W-1:0]];
            rd_idx  <= rd_idx + 16'd1;
          end
        end
        S_CSUM:  tx_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE) || pend_vld;

endmodule

// File: tb/tb_upload_frame_packer.sv
// Directed bench for upload_frame_packer with a 4-byte buffer and 16-cycle idle timeout.
module tb_upload_frame_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       upload_req = 1'b0;
  logic       upload_valid = 1'b0;
  logic [7:0] upload_data = 8'h00;
  logic [7:0] upload_source = 8'h00;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic [7:0] drop_cnt;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];

  upload_frame_packer #(.PAYLOAD_MAX(4), .IDLE_TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .upload_req    (upload_req),
    .upload_valid  (upload_valid),
    .upload_data   (upload_data),
    .upload_source (upload_source),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled at the following posedge.
  task automatic send(input logic [7:0] src, input logic [7:0] d);
    upload_req    = 1'b1;
    upload_valid  = 1'b1;
    upload_source = src;
    upload_data   = d;
    @(negedge clk);
    upload_req   = 1'b0;
    upload_valid = 1'b0;
  endtask

  // Last byte accepted on the previous posedge: tx_valid must rise exactly IDLE_TIMEOUT+1 edges later.
  task automatic chk_close(input string tag);
    repeat (16) @(negedge clk);
    chk({tag, "_early"}, 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
  endtask

  task automatic frame(input string tag, input int stall_at);
    int k;
    k = 0;
    while (!tx_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_start"}, 32'(tx_valid), 32'd1);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), 32'({tx_valid, tx_data}), 32'({1'b1, exp_q[i]}));
      if (i == stall_at) begin
        tx_ready = 1'b0;
        for (int j = 0; j < 20; j++) begin
          upload_req    = (j == 3) || (j == 8);
          upload_valid  = (j == 3) || (j == 8);
          upload_source = 8'h06;
          upload_data   = (j == 3) ? 8'h77 : 8'h88;
          @(negedge clk);
          chk($sformatf("%s_hold%0d", tag, j), 32'({tx_valid, tx_data}), 32'({1'b1, exp_q[i]}));
        end
        upload_req   = 1'b0;
        upload_valid = 1'b0;
        tx_ready     = 1'b1;
      end
      @(negedge clk);
    end
    chk({tag, "_end"}, 32'(tx_valid), 32'd0);
  endtask

  initial begin
    int k;
    #7;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Timeout close, bytes 10 cycles apart
    send(8'h06, 8'h11);
    repeat (9) @(negedge clk);
    send(8'h06, 8'h22);
    repeat (9) @(negedge clk);
    send(8'h06, 8'h33);
    chk("t1_busy", 32'(busy), 32'd1);
    chk_close("t1");
    exp_q = '{8'hAA, 8'h55, 8'h06, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6F};
    frame("t1", -1);
    chk("t1_idle", 32'(busy), 32'd0);

    // Full buffer close; fifth byte on the full cycle goes to the pending slot
    send(8'h06, 8'h01);
    repeat (2) @(negedge clk);
    send(8'h06, 8'h02);
    repeat (2) @(negedge clk);
    send(8'h06, 8'h03);
    repeat (2) @(negedge clk);
    send(8'h06, 8'h04);
    send(8'h06, 8'h05);
    exp_q = '{8'hAA, 8'h55, 8'h06, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h14};
    frame("t2a", -1);
    chk("t2_busy_pend", 32'(busy), 32'd1);
    chk("t2_drop", 32'(drop_cnt), 32'd0);
    exp_q = '{8'hAA, 8'h55, 8'h06, 8'h00, 8'h01, 8'h05, 8'h0C};
    frame("t2b", -1);

    // Source change closes the frame
    send(8'h06, 8'hA0);
    send(8'h04, 8'hB0);
    exp_q = '{8'hAA, 8'h55, 8'h06, 8'h00, 8'h01, 8'hA0, 8'hA7};
    frame("t3a", -1);
    exp_q = '{8'hAA, 8'h55, 8'h04, 8'h00, 8'h01, 8'hB0, 8'hB5};
    frame("t3b", -1);
    chk("t3_idle", 32'(busy), 32'd0);

    // Backpressure during PAY with two bytes offered: one pended, one dropped
    send(8'h06, 8'h11);
    send(8'h06, 8'h22);
    send(8'h06, 8'h33);
    exp_q = '{8'hAA, 8'h55, 8'h06, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6F};
    frame("t4a", 6);
    chk("t4_drop", 32'(drop_cnt), 32'd1);
    exp_q = '{8'hAA, 8'h55, 8'h06, 8'h00, 8'h01, 8'h77, 8'h7E};
    frame("t4b", -1);

    // Byte on the timeout cycle keeps the frame open
    send(8'h06, 8'h10);
    repeat (15) @(negedge clk);
    send(8'h06, 8'h20);
    chk_close("t5");
    exp_q = '{8'hAA, 8'h55, 8'h06, 8'h00, 8'h02, 8'h10, 8'h20, 8'h38};
    frame("t5", -1);

    // Reset in LEN_L, then a clean frame
    send(8'h06, 8'h5A);
    k = 0;
    while (!tx_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t6_start", 32'(tx_valid), 32'd1);
    repeat (4) @(negedge clk);
    chk("t6_len_l", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h01}));
    chk("t6_drop_pre", 32'(drop_cnt), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(tx_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h02, 8'h3C);
    chk_close("t6");
    exp_q = '{8'hAA, 8'h55, 8'h02, 8'h00, 8'h01, 8'h3C, 8'h3F};
    frame("t6", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
